// File: rtl/qcore_wreg_arbiter.sv
// Register-file write-port arbiter: pipeline writes win, external writes queue in a FIFO
// and drain on idle cycles; exports pending-address hits and a starvation stall request.
module qcore_wreg_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STARVE_LIM = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_we_i,
  input  logic [6:0]  core_addr_i,
  input  logic [31:0] core_dt_i,
  input  logic        ext_req_i,
  input  logic [6:0]  ext_addr_i,
  input  logic [31:0] ext_dt_i,
  output logic        ext_ack_o,
  input  logic [6:0]  rs_addr_i [2],
  output logic [1:0]  pend_hit_o,
  output logic        stall_o,
  output logic        reg_we_o,
  output logic [6:0]  reg_addr_o,
  output logic [31:0] reg_dt_o,
  output logic [4:0]  q_cnt_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = 39;

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [EW-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [4:0]    count_q, count_d;
  logic [7:0]    starve_q, starve_d;
  logic          stall_q, stall_d;
  logic          reg_we_q, reg_we_d;
  logic [6:0]    reg_addr_q, reg_addr_d;
  logic [31:0]   reg_dt_q, reg_dt_d;
  logic [EW-1:0] head;
  logic          push, pop;

  assign ext_ack_o = ~rst_i & (count_q < 5'(FIFO_DEPTH));
  assign push      = ext_req_i & ext_ack_o;
  // Pop only looks at the registered count, so a same-cycle push can never be popped.
  assign pop       = ~rst_i & ~core_we_i & (count_q != 5'd0);
  assign head      = mem_q[rd_q];

  always_comb begin
    mem_d      = mem_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    count_d    = count_q;
    reg_we_d   = 1'b0;
    reg_addr_d = reg_addr_q;
    reg_dt_d   = reg_dt_q;
    starve_d   = starve_q;
    stall_d    = stall_q;

    if (push) begin
      mem_d[wr_q] = {ext_addr_i, ext_dt_i};
      wr_d        = wr_q + PW'(1);
    end
    if (pop) begin
      rd_d = rd_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase

    if (core_we_i) begin
      reg_we_d   = 1'b1;
      reg_addr_d = core_addr_i;
      reg_dt_d   = core_dt_i;
    end else if (pop) begin
      reg_we_d   = 1'b1;
      reg_addr_d = head[38:32];
      reg_dt_d   = head[31:0];
    end

    if ((count_q == 5'd0) || pop) begin
      starve_d = 8'd0;
    end else if (starve_q != 8'hFF) begin
      starve_d = starve_q + 8'd1;
    end

    if (pop) begin
      stall_d = 1'b0;
    end else if (starve_q >= 8'(STARVE_LIM)) begin
      stall_d = 1'b1;
    end
  end

  // Scan queue slots by age; only the first count_q slots from the head are live.
  always_comb begin
    pend_hit_o = 2'b00;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (5'(i) < count_q) begin
        for (int unsigned k = 0; k < 2; k++) begin
          if (mem_q[PW'(rd_q + PW'(i))][38:32] == rs_addr_i[k]) begin
            pend_hit_o[k] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      stall_q    <= 1'b0;
      reg_we_q   <= 1'b0;
      reg_addr_q <= '0;
      reg_dt_q   <= '0;
    end else begin
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      stall_q    <= stall_d;
      reg_we_q   <= reg_we_d;
      reg_addr_q <= reg_addr_d;
      reg_dt_q   <= reg_dt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign stall_o    = stall_q;
  assign reg_we_o   = reg_we_q;
  assign reg_addr_o = reg_addr_q;
  assign reg_dt_o   = reg_dt_q;
  assign q_cnt_o    = count_q;

endmodule

// File: tb/tb_qcore_wreg_arbiter.sv
// Scoreboard bench for qcore_wreg_arbiter: directed scenarios plus random traffic against a
// queue-based reference model; a separate monitor checks every register-file write.
module tb_qcore_wreg_arbiter;

  localparam int D   = 4;
  localparam int LIM = 8;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        core_we_i;
  logic [6:0]  core_addr_i;
  logic [31:0] core_dt_i;
  logic        ext_req_i;
  logic [6:0]  ext_addr_i;
  logic [31:0] ext_dt_i;
  logic        ext_ack_o;
  logic [6:0]  rs_addr [2];
  logic [1:0]  pend_hit_o;
  logic        stall_o;
  logic        reg_we_o;
  logic [6:0]  reg_addr_o;
  logic [31:0] reg_dt_o;
  logic [4:0]  q_cnt_o;

  always #5 clk = ~clk;

  qcore_wreg_arbiter #(.FIFO_DEPTH(D), .STARVE_LIM(LIM)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .core_we_i(core_we_i), .core_addr_i(core_addr_i), .core_dt_i(core_dt_i),
    .ext_req_i(ext_req_i), .ext_addr_i(ext_addr_i), .ext_dt_i(ext_dt_i), .ext_ack_o(ext_ack_o),
    .rs_addr_i(rs_addr), .pend_hit_o(pend_hit_o), .stall_o(stall_o),
    .reg_we_o(reg_we_o), .reg_addr_o(reg_addr_o), .reg_dt_o(reg_dt_o), .q_cnt_o(q_cnt_o)
  );

  typedef struct {int cyc; logic [6:0] a; logic [31:0] d;} wr_t;
  typedef struct {logic [6:0] a; logic [31:0] d;} ent_t;

  wr_t  expq[$];   // expected register-file writes, stamped with the cycle they must appear
  ent_t mq[$];     // model of the external write queue
  int   m_starve;
  bit   m_stall;
  int   cyc;
  int   errs;
  int   checks;
  bit   chk_en;
  bit   last_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle of stimulus; checks visible state, then advances the model.
  task automatic step(input bit r, input bit cwe, input logic [6:0] ca, input logic [31:0] cd,
                      input bit req, input logic [6:0] ea, input logic [31:0] ed,
                      input logic [6:0] r0, input logic [6:0] r1);
    bit         acc, pop;
    int         sz;
    logic [1:0] ph;
    wr_t        w;
    ent_t       e;
    @(negedge clk);
    cyc++;
    rst_i = r; core_we_i = cwe; core_addr_i = ca; core_dt_i = cd;
    ext_req_i = req; ext_addr_i = ea; ext_dt_i = ed; rs_addr[0] = r0; rs_addr[1] = r1;
    #1;
    sz  = mq.size();
    acc = !r && (sz < D);
    ph  = 2'b00;
    foreach (mq[i]) begin
      if (mq[i].a == r0) ph[0] = 1'b1;
      if (mq[i].a == r1) ph[1] = 1'b1;
    end
    if (chk_en) begin
      chk("ext_ack", 64'(ext_ack_o), 64'(acc));
      chk("q_cnt", 64'(q_cnt_o), 64'(sz));
      chk("stall", 64'(stall_o), 64'(m_stall));
      chk("pend_hit", 64'(pend_hit_o), 64'(ph));
    end
    chk_en   = 1'b1;
    last_acc = acc && req;
    if (r) begin
      mq.delete();
      m_starve = 0;
      m_stall  = 1'b0;
    end else begin
      pop = !cwe && (sz > 0);
      if (cwe) begin
        w.cyc = cyc + 1; w.a = ca; w.d = cd;
        expq.push_back(w);
      end else if (pop) begin
        e = mq.pop_front();
        w.cyc = cyc + 1; w.a = e.a; w.d = e.d;
        expq.push_back(w);
      end
      if (pop) m_stall = 1'b0;
      else if (m_starve >= LIM) m_stall = 1'b1;
      if (pop || sz == 0) m_starve = 0;
      else if (m_starve < 255) m_starve++;
      if (last_acc) begin
        e.a = ea; e.d = ed;
        mq.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 7'h0, 32'h0, 1'b0, 7'h0, 32'h0, 7'h0, 7'h0);
  endtask

  // Monitor: every write the DUT presents must be the oldest expected one, on time.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      #2;
      if (reg_we_o === 1'b1) begin
        if (expq.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_write cyc=%0d got addr=%0h data=%0h want no write",
                   cyc, reg_addr_o, reg_dt_o);
        end else begin
          w = expq.pop_front();
          chk("wr_cycle", 64'(cyc), 64'(w.cyc));
          chk("wr_addr", 64'(reg_addr_o), 64'(w.a));
          chk("wr_data", 64'(reg_dt_o), 64'(w.d));
        end
      end else if (expq.size() > 0 && expq[0].cyc <= cyc) begin
        w = expq.pop_front();
        checks++;
        errs++;
        $display("FAIL missing_write cyc=%0d got reg_we=%b want addr=%0h data=%0h",
                 cyc, reg_we_o, w.a, w.d);
      end
    end
  end

  initial begin
    int k;
    int pc;
    errs = 0; checks = 0; cyc = 0; chk_en = 1'b0; m_starve = 0; m_stall = 1'b0;
    rst_i = 1'b1; core_we_i = 1'b0; core_addr_i = '0; core_dt_i = '0;
    ext_req_i = 1'b0; ext_addr_i = '0; ext_dt_i = '0; rs_addr[0] = '0; rs_addr[1] = '0;

    repeat (2) step(1'b1, 1'b0, 7'h0, 32'h0, 1'b0, 7'h0, 32'h0, 7'h0, 7'h0);

    // Single uncontended external write
    step(1'b0, 1'b0, 7'h0, 32'h0, 1'b1, 7'h05, 32'hDEADBEEF, 7'h0, 7'h0);
    idle(3);

    // Core and external write in the same cycle
    step(1'b0, 1'b1, 7'h10, 32'h1, 1'b1, 7'h11, 32'h2, 7'h0, 7'h0);
    idle(3);

    // Fill under continuous core writes until stall, then drain
    k = 0;
    for (int i = 0; i < 14; i++) begin
      step(1'b0, 1'b1, 7'(7'h40 + i), 32'(i), 1'b1, 7'(7'h30 + k), 32'(32'h100 + k),
           7'h30, 7'h33);
      if (last_acc) k++;
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 7'h0, 32'h0, (k < 5), 7'(7'h30 + k), 32'(32'h100 + k), 7'h30, 7'h34);
      if (last_acc) k++;
    end

    // Pending-hit on a queued entry
    step(1'b0, 1'b1, 7'h50, 32'h50, 1'b1, 7'h20, 32'hABCD, 7'h20, 7'h21);
    step(1'b0, 1'b1, 7'h51, 32'h51, 1'b0, 7'h0, 32'h0, 7'h20, 7'h21);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 7'h0, 32'h0, 1'b0, 7'h0, 32'h0, 7'h20, 7'h21);

    // Pointer wrap: back-to-back pushes and pops
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 7'h0, 32'h0, 1'b1, 7'(i), 32'(32'hA000 + i), 7'(i), 7'(i + 1));
    end
    idle(3);

    // Reset with entries queued and stall raised
    for (int i = 0; i < 14; i++) begin
      step(1'b0, 1'b1, 7'(7'h60 + i), 32'(i), (i < 3), 7'(7'h70 + i), 32'(32'hBB00 + i),
           7'h70, 7'h71);
    end
    step(1'b1, 1'b1, 7'h7F, 32'hFFFF, 1'b1, 7'h7E, 32'hEEEE, 7'h70, 7'h71);
    idle(4);

    // Random traffic with varying core-write density
    for (int i = 0; i < 3000; i++) begin
      pc = ((i / 200) % 4) * 33;
      step(($urandom_range(399) == 0), ($urandom_range(99) < pc), 7'($urandom_range(15)),
           $urandom, ($urandom_range(1) == 1), 7'($urandom_range(15)), $urandom,
           7'($urandom_range(15)), 7'($urandom_range(15)));
    end

    idle(20);
    repeat (3) @(negedge clk);
    chk("exp_drained", 64'(expq.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/qcore_wreg_arbiter.md
# qcore_wreg_arbiter

Register-file write-port arbiter for the qick processor core. The pipeline WR stage and an external write source share the core's single data-register write port; external sources are peripheral read-back and tproc control-port writes. Pipeline writes always win. External writes are buffered in a small FIFO and drained on idle write-port cycles. The block exports pending-write address hits so the hazard unit can bubble the RD stage on reads of registers with writes still queued. A starvation counter requests a pipeline stall when the queue cannot drain.

## Interface

Parameters:
- FIFO_DEPTH, 4, external write queue depth; power of 2, range 2..16.
- STARVE_LIM, 8, consecutive non-draining cycles with a non-empty queue before a stall is requested; range 2..255.

Ports:
- clk_i  in  1  core clock; single clock domain.
- rst_i  in  1  synchronous reset, active-high.
- core_we_i  in  1  WR-stage register write enable.
- core_addr_i  in  7  WR-stage register address.
- core_dt_i  in  32  WR-stage write data.
- ext_req_i  in  1  external write valid.
- ext_addr_i  in  7  external write address.
- ext_dt_i  in  32  external write data.
- ext_ack_o  out  1  external write accepted; a transfer occurs when ext_req_i & ext_ack_o.
- rs_addr_i[2]  in  7 each  RD-stage source register addresses.
- pend_hit_o  out  2  bit k high when rs_addr_i[k] matches any valid queued entry.
- stall_o  out  1  starvation stall request to the hazard unit.
- reg_we_o  out  1  register-file write enable.
- reg_addr_o  out  7  register-file write address.
- reg_dt_o  out  32  register-file write data.
- q_cnt_o  out  5  current queue occupancy.

## Operation

- Queue: circular FIFO with FIFO_DEPTH entries. Read and write pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. The count is 0..FIFO_DEPTH.
- ext_ack_o = ~rst_i & (count < FIFO_DEPTH), decoded from the registered count.
  - When count == FIFO_DEPTH, ack is 0 even if a pop occurs in the same cycle.
- Push: a handshake writes {ext_addr_i, ext_dt_i} at the write pointer. There is no bypass; an entry is never popped in the cycle it is pushed.
- Grant, evaluated every cycle in this priority order:
  1. core_we_i=1: output register loads core_addr_i/core_dt_i, reg_we_o=1 next cycle. No pop.
  2. else count>0: pop the head; output register loads the head, reg_we_o=1 next cycle.
  3. else reg_we_o=0 next cycle. Address and data hold their previous values.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Entries drain in FIFO order. Two external writes to the same address commit oldest first.
- pend_hit_o[k] is combinational: the OR over valid entries of (entry addr == rs_addr_i[k]).
  - Not set by the entry being pushed this cycle.
  - Not set by the output register contents.
- Starvation counter (8 bits):
  - Clears when count==0 or a pop occurs.
  - Otherwise increments by 1 per cycle and saturates at 255.
  - stall_o is registered: set when the counter reaches STARVE_LIM; cleared the cycle after a pop.
- Contract: the hazard unit blocks new register-writing instructions while stall_o=1, so core_we_i falls and the queue drains.
  - If core_we_i is nevertheless asserted, core still wins and no data is dropped; stall_o stays high.
- Reset (rst_i=1 at a clock edge):
  - Pointers, count and starvation counter go to 0; queued entries are discarded.
  - reg_we_o=0, reg_addr_o=0, reg_dt_o=0, stall_o=0, pend_hit_o=0, q_cnt_o=0.
  - ext_ack_o=0 while rst_i is high.
  - A handshake attempted in a reset cycle is ignored.

## Timing

- Core write: core_we_i sampled at edge E; reg_we_o=1 during the cycle after E. Fixed 1-cycle latency.
- External write, no contention: handshake at edge E; the entry is in the queue during the following cycle and popped at the next edge E+1; reg_we_o=1 in the cycle after E+1. Minimum latency is 2 cycles.
- Each cycle of core_we_i=1 delays the drain by exactly one cycle.
- stall_o rises one cycle after the counter equals STARVE_LIM and falls one cycle after the first pop.
- ext_ack_o rises the cycle after the pop that brings count below FIFO_DEPTH.
- pend_hit_o updates the cycle after a push (entry visible) and the cycle after a pop (entry removed).
- q_cnt_o equals the registered count; no extra latency.
- Full throughput: one register write per cycle whenever there is demand.

## Test plan

- Reset, then ext write addr 0x05 data 0xDEADBEEF with core idle -> ext_ack_o=1; reg_we_o=1, addr 0x05, data 0xDEADBEEF exactly 2 cycles after the handshake; q_cnt_o returns to 0.
- Simultaneous core write (0x10, 0x1) and ext write (0x11, 0x2), then core idle -> cycle+1 writes 0x10/0x1, cycle+2 writes 0x11/0x2.
- Push 4 ext writes (FIFO_DEPTH=4) under continuous core_we_i -> ext_ack_o=0 at count 4; a 5th request waits; stall_o=1 after 8 non-draining cycles; drop core_we_i -> entries drain in order, stall_o clears 1 cycle after the first pop.
- Queue holds addr 0x20; rs_addr_i={0x20,0x21} -> pend_hit_o=2'b01; after the pop, pend_hit_o=2'b00.
- Pointer wrap: 20 back-to-back pushes and pops with core idle -> 20 writes, all data correct and in order; count never exceeds 1.
- rst_i asserted with 3 entries queued and stall_o=1 -> next cycle q_cnt_o=0, stall_o=0, reg_we_o=0, pend_hit_o=0; discarded entries are never written.
